// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder backed by a small 32-bit register file.
// Frames are 40 bits, MSB first: {R/nW, addr[6:0], data[31:0]}. All logic runs on ACLK; the SPI
// pins are oversampled through synchronizers and SCLK edges are detected on the synced copy.
// Ports:
//   ACLK, ARESETN     system clock, asynchronous active-low reset
//   SCLK, SS_N, MOSI  SPI inputs from the master (CPOL=0, CPHA=0)
//   MISO, MISO_OE     SPI data out and its output enable (high while selected)
//   REGS              flattened register contents, reg k at [32k+31:32k]
//   FRAME_DONE        one-cycle pulse after a complete frame
//   ADDR_ERR          sticky, set when a frame addresses reg >= NUM_REGS
module spi_slave_regfile #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           SCLK,
  input  logic                           SS_N,
  input  logic                           MOSI,
  output logic                           MISO,
  output logic                           MISO_OE,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REGS,
  output logic                           FRAME_DONE,
  output logic                           ADDR_ERR
);

  localparam int unsigned IdxW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  NumRegsW  = 8'(NUM_REGS);
  // Counter value seen on the final data rise (8 command bits + data bits - 1).
  localparam logic [5:0]  LastCnt   = 6'(DATA_WIDTH + 7);
  localparam logic [5:0]  LastCmd   = 6'd7;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StWaitDesel} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_d, sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_d, ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_d, mosi_sync_q;
  logic                   sclk_prev_d, sclk_prev_q;

  state_e                 state_d, state_q;
  logic [5:0]             cnt_d, cnt_q;
  logic [6:0]             cmd_d, cmd_q;
  logic                   rnw_d, rnw_q;
  logic [6:0]             addr_d, addr_q;
  logic [DATA_WIDTH-1:0]  rx_d, rx_q;
  logic [DATA_WIDTH-1:0]  tx_d, tx_q;
  logic                   miso_d, miso_q;
  logic                   miso_oe_d, miso_oe_q;
  logic                   done_d, done_q;
  logic                   err_d, err_q;
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];

  logic       sclk_s, mosi_s, sel, rise, fall;
  logic [6:0] cmd_addr;
  logic       cmd_addr_ok, addr_ok;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign sel    = ~ss_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;

  // Address as it stands on the 8th command rise (last address bit still on MOSI).
  assign cmd_addr    = {cmd_q[5:0], mosi_s};
  assign cmd_addr_ok = {1'b0, cmd_addr} < NumRegsW;
  assign addr_ok     = {1'b0, addr_q} < NumRegsW;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_N};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    miso_oe_d   = sel;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    done_d  = 1'b0;
    err_d   = err_q;
    regs_d  = regs_q;
    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (sel) begin
          state_d = StCmd;
          cnt_d   = '0;
        end
      end
      StCmd: begin
        miso_d = 1'b0;
        if (!sel) begin
          state_d = StIdle;
        end else if (rise) begin
          cmd_d = cmd_addr;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastCmd) begin
            rnw_d   = cmd_q[6];
            addr_d  = cmd_addr;
            state_d = StData;
            tx_d    = '0;
            if (!cmd_addr_ok) begin
              err_d = 1'b1;
            end else if (cmd_q[6]) begin
              tx_d = regs_q[cmd_addr[IdxW-1:0]];
            end
          end
        end
      end
      StData: begin
        if (!sel) begin
          // Deselect wins even against a coincident final rise: frame is aborted.
          state_d = StIdle;
          miso_d  = 1'b0;
        end else if (rise) begin
          rx_d  = {rx_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastCnt) begin
            done_d  = 1'b1;
            state_d = StWaitDesel;
            miso_d  = 1'b0;
            if (!rnw_q && addr_ok) begin
              regs_d[addr_q[IdxW-1:0]] = {rx_q[DATA_WIDTH-2:0], mosi_s};
            end
          end
        end else if (fall) begin
          miso_d = rnw_q & tx_q[DATA_WIDTH-1];
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      StWaitDesel: begin
        miso_d = 1'b0;
        if (!sel) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      regs_q      <= '{default: '0};
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      regs_q      <= regs_d;
    end
  end

  assign MISO       = miso_q;
  assign MISO_OE    = miso_oe_q;
  assign FRAME_DONE = done_q;
  assign ADDR_ERR   = err_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign REGS[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: bit-bangs SPI mode-0 frames, keeps a register model, and
// checks read data through a queue of expected words.
module tb_spi_slave_regfile;
  localparam int unsigned NumRegs    = 4;
  localparam int unsigned SyncStages = 2;

  logic                   ACLK    = 1'b0;
  logic                   ARESETN = 1'b0;
  logic                   SCLK    = 1'b0;
  logic                   SS_N    = 1'b1;
  logic                   MOSI    = 1'b0;
  logic                   MISO;
  logic                   MISO_OE;
  logic [NumRegs*32-1:0]  REGS;
  logic                   FRAME_DONE;
  logic                   ADDR_ERR;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned done_cnt = 0;
  int unsigned done_ref;
  logic [31:0] model [NumRegs];
  logic [31:0] exp_q [$];
  logic [31:0] rd_dummy;

  spi_slave_regfile #(
    .NUM_REGS   (NumRegs),
    .DATA_WIDTH (32),
    .SYNC_STAGES(SyncStages)
  ) u_dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .SCLK      (SCLK),
    .SS_N      (SS_N),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .MISO_OE   (MISO_OE),
    .REGS      (REGS),
    .FRAME_DONE(FRAME_DONE),
    .ADDR_ERR  (ADDR_ERR)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) if (FRAME_DONE) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NumRegs; k++)
      check_eq($sformatf("%s_reg%0d", tag, k), REGS[32*k +: 32], model[k]);
  endtask

  // Drives nclk SCLK periods in one selection; leaves reset asserted instead of deselecting
  // when rst_at_end is set.
  task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] data, input int nclk,
                          input bit rst_at_end, output logic [31:0] rdata);
    logic [39:0] frame;
    logic        cmd_miso;
    frame    = {cmd, data};
    rdata    = '0;
    cmd_miso = 1'b0;
    SS_N     = 1'b0;
    wait_clk(6);
    check_eq("miso_oe_sel", 32'(MISO_OE), 32'd1);
    for (int i = 0; i < nclk; i++) begin
      MOSI = (i < 40) ? frame[39-i] : 1'b0;
      wait_clk(5);
      SCLK = 1'b1;
      if (i < 8) cmd_miso = cmd_miso | MISO;
      else if (i < 40) rdata = {rdata[30:0], MISO};
      wait_clk(5);
      SCLK = 1'b0;
    end
    check_eq("miso_cmd_phase", 32'(cmd_miso), 32'd0);
    if (rst_at_end) begin
      ARESETN = 1'b0;
    end else begin
      wait_clk(5);
      SS_N = 1'b1;
      MOSI = 1'b0;
      wait_clk(SyncStages + 4);
    end
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [31:0] d, input int nclk);
    spi_xfer({1'b0, a}, d, nclk, 1'b0, rd_dummy);
    if (nclk >= 40 && int'(a) < NumRegs) model[a[1:0]] = d;
  endtask

  task automatic spi_read(input logic [6:0] a);
    logic [31:0] rd;
    exp_q.push_back((int'(a) < NumRegs) ? model[a[1:0]] : 32'h0);
    spi_xfer({1'b1, a}, 32'h0, 40, 1'b0, rd);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got %h expected none", rd);
    end else begin
      check_eq($sformatf("read_a%0d", a), rd, exp_q.pop_front());
    end
  endtask

  initial begin
    for (int k = 0; k < NumRegs; k++) model[k] = '0;
    #23;
    check_regs("reset");
    check_eq("reset_miso_oe", 32'(MISO_OE), 32'd0);
    check_eq("reset_miso", 32'(MISO), 32'd0);
    check_eq("reset_addr_err", 32'(ADDR_ERR), 32'd0);
    check_eq("reset_frame_done", 32'(FRAME_DONE), 32'd0);
    wait_clk(2);
    ARESETN = 1'b1;
    wait_clk(4);

    // Single write to reg 0.
    done_ref = done_cnt;
    spi_write(7'd0, 32'h0000_0001, 40);
    check_regs("wr0");
    check_eq("wr0_done", done_cnt - done_ref, 32'd1);
    check_eq("wr0_addr_err", 32'(ADDR_ERR), 32'd0);

    // Fill all registers then read them back.
    for (int a = 1; a < NumRegs; a++) spi_write(7'(a), 32'(a + 1), 40);
    for (int a = 0; a < NumRegs; a++) spi_read(7'(a));
    check_regs("after_reads");

    // Out-of-range write and read.
    done_ref = done_cnt;
    spi_write(7'd5, 32'hCAFE_F00D, 40);
    check_regs("oor_wr");
    check_eq("oor_addr_err", 32'(ADDR_ERR), 32'd1);
    check_eq("oor_done", done_cnt - done_ref, 32'd1);
    spi_read(7'd5);

    // Aborted write after 20 data bits, then a full one.
    done_ref = done_cnt;
    spi_write(7'd2, 32'hA5A5_A5A5, 28);
    check_regs("abort");
    check_eq("abort_done", done_cnt - done_ref, 32'd0);
    spi_write(7'd2, 32'h1234_5678, 40);
    check_regs("post_abort");

    // Extra clocks inside one selection are ignored.
    done_ref = done_cnt;
    spi_write(7'd1, 32'h89AB_CDEF, 48);
    check_regs("long_sel");
    check_eq("long_sel_done", done_cnt - done_ref, 32'd1);

    // Reset in the data phase of a write.
    spi_xfer({1'b0, 7'd3}, 32'hDEAD_BEEF, 20, 1'b1, rd_dummy);
    #1;
    for (int k = 0; k < NumRegs; k++) model[k] = '0;
    check_regs("mid_rst");
    check_eq("mid_rst_miso_oe", 32'(MISO_OE), 32'd0);
    check_eq("mid_rst_addr_err", 32'(ADDR_ERR), 32'd0);
    wait_clk(3);
    SS_N = 1'b1;
    MOSI = 1'b0;
    wait_clk(2);
    ARESETN = 1'b1;
    wait_clk(8);
    spi_write(7'd3, 32'h5555_AAAA, 40);
    check_regs("post_rst");
    spi_read(7'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
